// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// The receive side imports this package as well.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Any mode other than even/odd (including the unused code 3) means no parity bit.
    function automatic logic parity_enabled(input int unsigned mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-word valid/ready handshake feeding the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period divider: one-cycle tick every CLKS_PER_BIT cycles while run is high.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, one stop bit.
// All outputs are registered and change on the same edge as the FSM state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy
);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_EN  = parity_enabled(PARITY);
    localparam logic PAR_INV = (PARITY == PAR_ODD);

    uart_state_e          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_bit;
    logic                 ready_q;
    logic                 run;
    logic                 tick;

    assign run          = (state != ST_IDLE);
    assign bus.tx_ready = ready_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            ready_q   <= 1'b0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    // ready_q is the registered flag, so no accept on the edge leaving reset
                    if (bus.tx_valid && ready_q) begin
                        shift_reg <= bus.tx_data;
                        par_bit   <= (^bus.tx_data) ^ PAR_INV;
                        bit_idx   <= '0;
                        state     <= ST_START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state     <= ST_DATA;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (PAR_EN) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state   <= ST_IDLE;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/even/odd parity) checked every cycle against a
// frame-level model, plus directed scenarios with hand-computed line patterns.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tv[3];
    logic [7:0] td[3];
    logic [2:0] dtx, drdy, dbusy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(DB)) bus0 ();
    uart_tx_if #(.DATA_BITS(DB)) bus1 ();
    uart_tx_if #(.DATA_BITS(DB)) bus2 ();

    assign bus0.tx_valid = tv[0];
    assign bus1.tx_valid = tv[1];
    assign bus2.tx_valid = tv[2];
    assign bus0.tx_data  = td[0];
    assign bus1.tx_data  = td[1];
    assign bus2.tx_data  = td[2];
    assign drdy[0] = bus0.tx_ready;
    assign drdy[1] = bus1.tx_ready;
    assign drdy[2] = bus2.tx_ready;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR_NONE)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .tx(dtx[0]), .busy(dbusy[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR_EVEN)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .tx(dtx[1]), .busy(dbusy[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR_ODD)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .tx(dtx[2]), .busy(dbusy[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    function automatic int flen(input int d);
        return (d == 0) ? 10 : 11;
    endfunction

    function automatic logic [15:0] build(input int d, input logic [7:0] w);
        logic [15:0] f = '0;
        int ones = 0;
        for (int i = 0; i < DB; i++) begin
            f[1+i] = w[i];
            if (w[i]) ones++;
        end
        if (d == 1) f[9] = (ones % 2 == 1);
        if (d == 2) f[9] = (ones % 2 == 0);
        f[flen(d)-1] = 1'b1;
        return f;
    endfunction

    int          m_pos[3];
    logic        m_tx[3], m_rdy[3], m_busy[3];
    logic [15:0] m_frame[3];
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_live    = 1'b1;
                m_pos[d]  = -1;
                m_rdy[d]  = 1'b0;
                m_busy[d] = 1'b0;
                m_tx[d]   = 1'b1;
            end else if (m_pos[d] < 0) begin
                if (tv[d] && m_rdy[d]) begin
                    m_frame[d] = build(d, td[d]);
                    m_pos[d]   = 0;
                    m_tx[d]    = m_frame[d][0];
                    m_rdy[d]   = 1'b0;
                    m_busy[d]  = 1'b1;
                end else begin
                    m_rdy[d]  = 1'b1;
                    m_busy[d] = 1'b0;
                    m_tx[d]   = 1'b1;
                end
            end else begin
                m_pos[d]++;
                if (m_pos[d] == flen(d) * CPB) begin
                    m_pos[d]  = -1;
                    m_rdy[d]  = 1'b1;
                    m_busy[d] = 1'b0;
                    m_tx[d]   = 1'b1;
                end else begin
                    m_tx[d] = m_frame[d][m_pos[d] / CPB];
                end
            end
        end
        #1;
        if (m_live) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("model_tx_d%0d", d),    32'(dtx[d]),   32'(m_tx[d]));
                chk($sformatf("model_ready_d%0d", d), 32'(drdy[d]),  32'(m_rdy[d]));
                chk($sformatf("model_busy_d%0d", d),  32'(dbusy[d]), 32'(m_busy[d]));
            end
        end
    end

    // ---------------- capture helpers ----------------
    logic cap_tx[3][100], cap_rdy[3][100], cap_busy[3][100];

    // Index 0 is the sample just after the next posedge (the accept edge).
    task automatic capture(input int d, input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            cap_tx[d][j]   = dtx[d];
            cap_rdy[d][j]  = drdy[d];
            cap_busy[d][j] = dbusy[d];
        end
    endtask

    task automatic check_frame(input string nm, input int d, input logic [15:0] exp, input int nbits);
        logic [3:0] s;
        for (int b = 0; b < nbits; b++) begin
            s = {cap_tx[d][CPB*b+3], cap_tx[d][CPB*b+2], cap_tx[d][CPB*b+1], cap_tx[d][CPB*b]};
            chk($sformatf("%s_bit%0d", nm, b), 32'(s), exp[b] ? 32'hF : 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int viol, low_run, gap, cnt;
        for (int d = 0; d < 3; d++) begin
            tv[d] = 1'b0;
            td[d] = '0;
        end

        // reset state
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_tx",    32'(dtx),   32'h7);
            chk("reset_ready", 32'(drdy),  32'h0);
            chk("reset_busy",  32'(dbusy), 32'h0);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(drdy), 32'h7);

        // idle with tx_valid low
        viol = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (dtx !== 3'b111 || dbusy !== 3'b000 || drdy !== 3'b111) viol++;
        end
        chk("idle_100_violations", 32'(viol), 32'h0);

        // single frame 0xA5, no parity
        @(negedge clk);
        tv[0] = 1'b1;
        td[0] = 8'hA5;
        fork
            capture(0, 50);
            begin @(negedge clk); tv[0] = 1'b0; end
        join
        check_frame("a5", 0, 16'b1101001010, 10);
        low_run = 0;
        while (low_run < 50 && cap_rdy[0][low_run] == 1'b0) low_run++;
        chk("a5_ready_low_cycles", 32'(low_run), 32'd40);
        chk("a5_busy_last", 32'(cap_busy[0][39]), 32'h1);
        chk("a5_busy_done", 32'(cap_busy[0][40]), 32'h0);

        // back-to-back 0x00 then 0xFF with tx_valid held
        repeat (3) @(negedge clk);
        tv[0] = 1'b1;
        td[0] = 8'h00;
        fork
            capture(0, 90);
            begin
                @(negedge clk);
                td[0] = 8'hFF;
                repeat (41) @(negedge clk);
                tv[0] = 1'b0;
            end
        join
        gap = -1;
        for (int j = 1; j < 90; j++)
            if (gap < 0 && cap_tx[0][j-1] == 1'b1 && cap_tx[0][j] == 1'b0) gap = j;
        chk("b2b_second_start", 32'(gap), 32'd41);
        cnt = 0;
        for (int j = 0; j <= 80; j++) if (cap_busy[0][j] == 1'b0) cnt++;
        chk("b2b_busy_gap_cycles", 32'(cnt), 32'd1);
        chk("b2b_idle_high", 32'(cap_tx[0][40]), 32'h1);
        cnt = 0;
        for (int j = 45; j <= 76; j++) if (cap_tx[0][j] == 1'b1) cnt++;
        chk("b2b_ff_data_ones", 32'(cnt), 32'd32);

        // parity: 0x07 on even and odd instances
        repeat (3) @(negedge clk);
        tv[1] = 1'b1; td[1] = 8'h07;
        tv[2] = 1'b1; td[2] = 8'h07;
        fork
            capture(1, 50);
            capture(2, 50);
            begin @(negedge clk); tv[1] = 1'b0; tv[2] = 1'b0; end
        join
        check_frame("p_even", 1, 16'b11000001110, 11);
        check_frame("p_odd",  2, 16'b10000001110, 11);
        chk("p_even_ready_end", 32'(cap_rdy[1][44]), 32'h1);
        chk("p_odd_ready_end",  32'(cap_rdy[2][44]), 32'h1);
        chk("p_even_ready_stop", 32'(cap_rdy[1][43]), 32'h0);

        // reset during data bit 3 of 0x3C
        repeat (3) @(negedge clk);
        tv[0] = 1'b1;
        td[0] = 8'h3C;
        @(posedge clk);
        #1;
        chk("rst_mid_accepted", 32'(dbusy[0]), 32'h1);
        @(negedge clk) tv[0] = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_mid_tx",    32'(dtx[0]),   32'h1);
            chk("rst_mid_ready", 32'(drdy[0]),  32'h0);
            chk("rst_mid_busy",  32'(dbusy[0]), 32'h0);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ready_release", 32'(drdy[0]), 32'h1);
        @(negedge clk);
        tv[0] = 1'b1;
        td[0] = 8'h81;
        fork
            capture(0, 45);
            begin @(negedge clk); tv[0] = 1'b0; end
        join
        check_frame("post_rst_81", 0, 16'b1100000010, 10);

        // tx_data changes and tx_valid pulses while busy
        repeat (3) @(negedge clk);
        tv[0] = 1'b1;
        td[0] = 8'hC3;
        fork
            capture(0, 55);
            begin
                @(negedge clk);
                tv[0] = 1'b0;
                td[0] = 8'h00;
                repeat (10) @(negedge clk);
                tv[0] = 1'b1;
                @(negedge clk);
                tv[0] = 1'b0;
            end
        join
        check_frame("stable_c3", 0, 16'b1110000110, 10);
        cnt = 0;
        for (int j = 40; j < 55; j++) if (cap_busy[0][j] != 1'b0 || cap_tx[0][j] != 1'b1) cnt++;
        chk("no_extra_frame", 32'(cnt), 32'h0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
